bs_port_endpoint: RTL and testbench
===================================

Name: bs_port_endpoint

Overview:
- Node-side endpoint for one driver slot of the bs_gnrtr bus.
- TX direction: node packets go into a TX FIFO. The endpoint presents them to the bus through pndng/D_pop and retires one on each bus pop.
- RX direction: accepts bus push/D_push, filters on the target field and buffers accepted packets in an RX FIFO for the node.
- Packet format is fixed: [PCKG_SZ-1:PCKG_SZ-8] target, [PCKG_SZ-9:PCKG_SZ-16] source, [PCKG_SZ-17:PCKG_SZ-32] sequence ID, remainder payload.

Parameters:
- PCKG_SZ, 128, packet width in bits (>=40).
- DEPTH, 8, entries per FIFO; power of two, >=2.
- ID, 8'd0, this endpoint's bus address.
- BROADCAST, 8'hFF, broadcast target address.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  out  1  TX FIFO non-empty, to bus.
- D_pop  out  PCKG_SZ  TX FIFO head packet, to bus.
- pop  in  1  bus consumed head packet.
- push  in  1  bus delivers D_push this cycle.
- D_push  in  PCKG_SZ  packet from bus.
- tx_wr  in  1  node enqueue strobe.
- tx_target  in  8  destination for enqueued packet.
- tx_payload  in  PCKG_SZ-32  payload for enqueued packet.
- tx_full  out  1  TX FIFO full.
- tx_cnt  out  $clog2(DEPTH)+1  TX occupancy.
- rx_rd  in  1  node dequeue strobe.
- rx_vld  out  1  RX FIFO non-empty.
- rx_data  out  PCKG_SZ  RX FIFO head packet.
- rx_cnt  out  $clog2(DEPTH)+1  RX occupancy.
- drop_cnt  out  16  packets rejected by the address filter.
- ovf_cnt  out  16  accepted packets lost because RX was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers and counts go to 0; pndng=0, tx_full=0, rx_vld=0.
  - D_pop=0, rx_data=0.
  - tx_seq, drop_cnt and ovf_cnt go to 0.
  - FIFO contents are discarded.
  - Reset asserted mid-transfer loses all queued packets; no partial state survives.
- TX enqueue:
  - On a tx_wr edge with tx_full=0, store {tx_target, ID, tx_seq, tx_payload} and increment tx_seq (16-bit, wraps FFFF->0000).
  - tx_wr while tx_full=1 is ignored, even if pop arrives the same cycle; tx_seq does not advance.
- TX to bus:
  - pndng = (tx_cnt!=0) and D_pop = mem[rd_ptr], both registered-state based, show-ahead.
  - D_pop is forced to 0 when the FIFO is empty.
  - No fall-through: a write into an empty FIFO raises pndng on the next cycle.
  - pop with pndng=1 advances rd_ptr. pop with pndng=0 is ignored.
  - The bus may pop on consecutive cycles.
  - Simultaneous accepted write and pop leaves tx_cnt unchanged.
- RX filter, evaluated in the push cycle:
  - A packet is accepted iff target==ID, or target==BROADCAST and source!=ID (self-broadcast echo suppressed).
  - Rejected packets increment drop_cnt.
- RX store:
  - An accepted packet is written if rx_cnt<DEPTH, or if rx_cnt==DEPTH and rx_rd is asserted the same cycle (a simultaneous read frees the slot).
  - Otherwise the packet is discarded and ovf_cnt increments.
  - Write-to-read latency is 1 cycle: rx_vld rises the cycle after the push.
- RX read:
  - rx_rd with rx_vld=1 advances the head.
  - rx_data = head, or 0 when empty.
  - rx_rd with rx_vld=0 is ignored.
- Counters: drop_cnt and ovf_cnt saturate at 16'hFFFF.
- Pointers: $clog2(DEPTH) bits, wrap naturally.
- Counts: range 0..DEPTH and never exceed DEPTH.

Test Plan:
1. Reset, ID=1; tx_wr three times with tx_target=2 and payloads A,B,C; pop on 3 consecutive cycles -> D_pop shows {02,01,0000,A}, then {02,01,0001,B}, then {02,01,0002,C}; pndng falls after the third pop; tx_cnt 3->0.
2. Fill TX (8 writes, DEPTH=8) -> tx_full=1. A 9th tx_wr together with pop -> write dropped, tx_cnt=7, next enqueued packet carries seq 0008.
3. ID=1; push targets 01, FF (source 03), FF (source 01), 05 -> rx_cnt=2, drop_cnt=2; rx_data shows target 01 then target FF.
4. Push 8 accepted packets with no reads -> rx_cnt=8. A 9th push -> ovf_cnt=1. A 10th push with rx_rd the same cycle -> stored, rx_cnt=8, ovf_cnt stays 1.
5. Enqueue 65537 packets with continuous pop -> seq wraps, last packet ID=0000. Force 65540 rejected pushes -> drop_cnt=FFFF.
6. Assert reset low mid-stream with TX=4, RX=3 -> pndng, rx_vld, counts and counters go to 0 immediately without waiting for a clock; the first packet after release carries seq 0000.

Source files
------------

// File: rtl/bs_port_endpoint_if.sv
// Bus and node signal bundle for one bs_gnrtr driver slot endpoint.
// The slave modport is the endpoint side; master is the bus/node environment.
interface bs_port_endpoint_if #(
  parameter int PCKG_SZ = 128,
  parameter int DEPTH   = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [PCKG_SZ-1:0] D_push;

  logic                  tx_wr;
  logic [7:0]            tx_target;
  logic [PCKG_SZ-33:0]   tx_payload;
  logic                  tx_full;
  logic [CW-1:0]         tx_cnt;

  logic               rx_rd;
  logic               rx_vld;
  logic [PCKG_SZ-1:0] rx_data;
  logic [CW-1:0]      rx_cnt;
  logic [15:0]        drop_cnt;
  logic [15:0]        ovf_cnt;

  modport slave (
    input  pop, push, D_push, tx_wr, tx_target, tx_payload, rx_rd,
    output pndng, D_pop, tx_full, tx_cnt, rx_vld, rx_data, rx_cnt, drop_cnt, ovf_cnt
  );

  modport master (
    output pop, push, D_push, tx_wr, tx_target, tx_payload, rx_rd,
    input  pndng, D_pop, tx_full, tx_cnt, rx_vld, rx_data, rx_cnt, drop_cnt, ovf_cnt
  );
endinterface

// File: rtl/bs_port_endpoint.sv
// Node-side endpoint for a bs_gnrtr driver slot: show-ahead TX FIFO toward the bus,
// address-filtered RX FIFO toward the node, with drop/overflow statistics.
module bs_port_endpoint #(
  parameter int         PCKG_SZ   = 128,
  parameter int         DEPTH     = 8,
  parameter logic [7:0] ID        = 8'd0,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input logic               clk,
  input logic               reset,
  bs_port_endpoint_if.slave ep
);
  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------- TX path ----------------
  logic [PCKG_SZ-1:0] r_tx_mem [DEPTH];
  logic [AW-1:0]      r_tx_wr_ptr;
  logic [AW-1:0]      r_tx_rd_ptr;
  logic [CW-1:0]      r_tx_cnt;
  logic [15:0]        r_tx_seq;

  logic               w_tx_full;
  logic               w_tx_wr_ok;
  logic               w_tx_pop_ok;
  logic [PCKG_SZ-1:0] w_tx_pkt;

  assign w_tx_full   = (r_tx_cnt == FULL_CNT);
  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign w_tx_wr_ok  = ep.tx_wr & ~w_tx_full;
  assign w_tx_pop_ok = ep.pop & (r_tx_cnt != '0);
  assign w_tx_pkt    = {ep.tx_target, ID, r_tx_seq, ep.tx_payload};

  always_ff @(posedge clk) begin
    if (w_tx_wr_ok) begin
      r_tx_mem[r_tx_wr_ptr] <= w_tx_pkt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_cnt    <= '0;
      r_tx_seq    <= '0;
    end else begin
      if (w_tx_wr_ok) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
        r_tx_seq    <= r_tx_seq + 16'd1;
      end
      if (w_tx_pop_ok) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      end
      case ({w_tx_wr_ok, w_tx_pop_ok})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  assign ep.pndng   = (r_tx_cnt != '0);
  assign ep.D_pop   = (r_tx_cnt != '0) ? r_tx_mem[r_tx_rd_ptr] : '0;
  assign ep.tx_full = w_tx_full;
  assign ep.tx_cnt  = r_tx_cnt;

  // ---------------- RX path ----------------
  logic [PCKG_SZ-1:0] r_rx_mem [DEPTH];
  logic [AW-1:0]      r_rx_wr_ptr;
  logic [AW-1:0]      r_rx_rd_ptr;
  logic [CW-1:0]      r_rx_cnt;
  logic [15:0]        r_drop_cnt;
  logic [15:0]        r_ovf_cnt;

  logic [7:0] w_rx_target;
  logic [7:0] w_rx_source;
  logic       w_rx_accept;
  logic       w_rx_drop;
  logic       w_rx_rd_ok;
  logic       w_rx_wr_ok;
  logic       w_rx_ovf;

  assign w_rx_target = ep.D_push[PCKG_SZ-1:PCKG_SZ-8];
  assign w_rx_source = ep.D_push[PCKG_SZ-9:PCKG_SZ-16];
  // Broadcasts we sent ourselves come back on the bus and must not be re-delivered.
  assign w_rx_accept = ep.push & ((w_rx_target == ID) |
                                  ((w_rx_target == BROADCAST) & (w_rx_source != ID)));
  assign w_rx_drop   = ep.push & ~w_rx_accept;
  assign w_rx_rd_ok  = ep.rx_rd & (r_rx_cnt != '0);
  assign w_rx_wr_ok  = w_rx_accept & ((r_rx_cnt != FULL_CNT) | w_rx_rd_ok);
  assign w_rx_ovf    = w_rx_accept & ~w_rx_wr_ok;

  always_ff @(posedge clk) begin
    if (w_rx_wr_ok) begin
      r_rx_mem[r_rx_wr_ptr] <= ep.D_push;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_rx_wr_ok) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      end
      if (w_rx_rd_ok) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      end
      case ({w_rx_wr_ok, w_rx_rd_ok})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (w_rx_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_rx_ovf && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  assign ep.rx_vld   = (r_rx_cnt != '0);
  assign ep.rx_data  = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rd_ptr] : '0;
  assign ep.rx_cnt   = r_rx_cnt;
  assign ep.drop_cnt = r_drop_cnt;
  assign ep.ovf_cnt  = r_ovf_cnt;
endmodule

// File: tb/tb_bs_port_endpoint.sv
// Directed bench for bs_port_endpoint (ID=01, DEPTH=8, 128-bit packets).
module tb_bs_port_endpoint;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bs_port_endpoint_if #(.PCKG_SZ(128), .DEPTH(8)) ep_if ();

  bs_port_endpoint #(
    .PCKG_SZ(128), .DEPTH(8), .ID(8'h01), .BROADCAST(8'hFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ep   (ep_if)
  );

  function automatic logic [127:0] mk_pkt(input logic [7:0] t, input logic [7:0] s,
                                          input logic [15:0] seq, input logic [95:0] pl);
    return {t, s, seq, pl};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s: ok (%h)", tag, got);
    end
  endtask

  // One clock edge; returns on the following falling edge, where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    ep_if.pop = 0; ep_if.push = 0; ep_if.D_push = '0; ep_if.tx_wr = 0;
    ep_if.tx_target = '0; ep_if.tx_payload = '0; ep_if.rx_rd = 0;

    // Reset state
    step();
    check("rst_pndng",   128'(ep_if.pndng),   128'(0));
    check("rst_tx_full", 128'(ep_if.tx_full), 128'(0));
    check("rst_rx_vld",  128'(ep_if.rx_vld),  128'(0));
    check("rst_D_pop",   ep_if.D_pop,         128'(0));
    check("rst_rx_data", ep_if.rx_data,       128'(0));
    check("rst_tx_cnt",  128'(ep_if.tx_cnt),  128'(0));
    check("rst_drop",    128'(ep_if.drop_cnt), 128'(0));
    reset = 1'b1;

    // 1: three enqueues, three back-to-back pops
    ep_if.tx_target = 8'h02;
    ep_if.tx_wr = 1; ep_if.tx_payload = 96'hA; step();
    check("t1_pndng_next", 128'(ep_if.pndng), 128'(1));
    ep_if.tx_payload = 96'hB; step();
    ep_if.tx_payload = 96'hC; step();
    ep_if.tx_wr = 0;
    check("t1_cnt3", 128'(ep_if.tx_cnt), 128'(3));
    check("t1_pkA", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0000, 96'hA));
    ep_if.pop = 1; step();
    check("t1_pkB", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0001, 96'hB));
    step();
    check("t1_pkC", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0002, 96'hC));
    step();
    ep_if.pop = 0;
    check("t1_pndng0", 128'(ep_if.pndng), 128'(0));
    check("t1_cnt0", 128'(ep_if.tx_cnt), 128'(0));
    check("t1_dpop0", ep_if.D_pop, 128'(0));

    // 2: fill TX, write-while-full with pop is dropped
    apply_reset();
    ep_if.tx_wr = 1;
    for (int i = 0; i < 8; i++) begin
      ep_if.tx_payload = 96'(i); step();
    end
    check("t2_full", 128'(ep_if.tx_full), 128'(1));
    check("t2_cnt8", 128'(ep_if.tx_cnt), 128'(8));
    ep_if.tx_payload = 96'h99; ep_if.pop = 1; step();
    ep_if.pop = 0;
    check("t2_cnt7", 128'(ep_if.tx_cnt), 128'(7));
    check("t2_head1", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0001, 96'h1));
    ep_if.tx_payload = 96'hAA; step();
    ep_if.tx_wr = 0; ep_if.pop = 1;
    repeat (7) step();
    ep_if.pop = 0;
    check("t2_seq8", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0008, 96'hAA));
    ep_if.pop = 1; step(); step();
    ep_if.pop = 0;
    check("t2_pop_empty", 128'(ep_if.tx_cnt), 128'(0));

    // 3: address filter
    apply_reset();
    ep_if.push = 1;
    ep_if.D_push = mk_pkt(8'h01, 8'h03, 16'h0010, 96'h1); step();
    check("t3_vld_lat", 128'(ep_if.rx_vld), 128'(1));
    ep_if.D_push = mk_pkt(8'hFF, 8'h03, 16'h0011, 96'h2); step();
    ep_if.D_push = mk_pkt(8'hFF, 8'h01, 16'h0012, 96'h3); step();
    ep_if.D_push = mk_pkt(8'h05, 8'h03, 16'h0013, 96'h4); step();
    ep_if.push = 0;
    check("t3_rx_cnt", 128'(ep_if.rx_cnt), 128'(2));
    check("t3_drop", 128'(ep_if.drop_cnt), 128'(2));
    check("t3_head01", ep_if.rx_data, mk_pkt(8'h01, 8'h03, 16'h0010, 96'h1));
    ep_if.rx_rd = 1; step();
    check("t3_headFF", ep_if.rx_data, mk_pkt(8'hFF, 8'h03, 16'h0011, 96'h2));
    step(); step();
    ep_if.rx_rd = 0;
    check("t3_empty_vld", 128'(ep_if.rx_vld), 128'(0));
    check("t3_empty_data", ep_if.rx_data, 128'(0));
    check("t3_rd_empty_cnt", 128'(ep_if.rx_cnt), 128'(0));

    // 4: RX full, overflow, and full-with-read
    ep_if.push = 1;
    for (int i = 0; i < 8; i++) begin
      ep_if.D_push = mk_pkt(8'h01, 8'h03, 16'(i), 96'(i)); step();
    end
    check("t4_cnt8", 128'(ep_if.rx_cnt), 128'(8));
    ep_if.D_push = mk_pkt(8'h01, 8'h03, 16'd8, 96'd8); step();
    check("t4_ovf1", 128'(ep_if.ovf_cnt), 128'(1));
    ep_if.D_push = mk_pkt(8'h01, 8'h03, 16'd9, 96'd9); ep_if.rx_rd = 1; step();
    ep_if.push = 0; ep_if.rx_rd = 0;
    check("t4_cnt8_rd", 128'(ep_if.rx_cnt), 128'(8));
    check("t4_ovf_stay", 128'(ep_if.ovf_cnt), 128'(1));
    ep_if.rx_rd = 1;
    repeat (7) step();
    ep_if.rx_rd = 0;
    check("t4_last", ep_if.rx_data, mk_pkt(8'h01, 8'h03, 16'd9, 96'd9));

    // 5: seq wrap and drop_cnt saturation, run concurrently
    apply_reset();
    ep_if.tx_target = 8'h02; ep_if.tx_payload = 96'h5A5A;
    ep_if.tx_wr = 1; ep_if.pop = 1;
    ep_if.push = 1; ep_if.D_push = mk_pkt(8'h05, 8'h03, 16'h0, 96'h0);
    repeat (65536) step();
    check("t5_cnt1", 128'(ep_if.tx_cnt), 128'(1));
    check("t5_seqFFFF", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'hFFFF, 96'h5A5A));
    ep_if.tx_wr = 0; step();
    check("t5_drained", 128'(ep_if.tx_cnt), 128'(0));
    ep_if.pop = 0; ep_if.tx_wr = 1; ep_if.tx_payload = 96'hBEEF; step();
    ep_if.tx_wr = 0;
    check("t5_seq_wrap", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0000, 96'hBEEF));
    step(); step();
    ep_if.push = 0;
    check("t5_drop_sat", 128'(ep_if.drop_cnt), 128'(16'hFFFF));
    check("t5_ovf0", 128'(ep_if.ovf_cnt), 128'(0));

    // 6: asynchronous reset mid-stream
    apply_reset();
    ep_if.tx_wr = 1; ep_if.push = 1;
    ep_if.D_push = mk_pkt(8'h01, 8'h03, 16'h0, 96'h0); step();
    step(); step();
    ep_if.D_push = mk_pkt(8'h07, 8'h03, 16'h0, 96'h0); step();
    ep_if.tx_wr = 0; ep_if.push = 0;
    check("t6_tx4", 128'(ep_if.tx_cnt), 128'(4));
    check("t6_rx3", 128'(ep_if.rx_cnt), 128'(3));
    #2 reset = 1'b0;
    #1;
    check("t6_pndng", 128'(ep_if.pndng), 128'(0));
    check("t6_rx_vld", 128'(ep_if.rx_vld), 128'(0));
    check("t6_tx_cnt", 128'(ep_if.tx_cnt), 128'(0));
    check("t6_rx_cnt", 128'(ep_if.rx_cnt), 128'(0));
    check("t6_drop", 128'(ep_if.drop_cnt), 128'(0));
    check("t6_dpop", ep_if.D_pop, 128'(0));
    @(negedge clk);
    reset = 1'b1;
    ep_if.tx_wr = 1; ep_if.tx_payload = 96'h77; step();
    ep_if.tx_wr = 0;
    check("t6_seq0", ep_if.D_pop, mk_pkt(8'h02, 8'h01, 16'h0000, 96'h77));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
